wordle_guess_scorer: RTL and testbench

- Scores one submitted 5-letter guess against the secret word, with correct Wordle duplicate-letter rules.
- Writes each guess letter and its colour into the board memory that the VGA renderer reads.
- It is the writer side of the board interface: it sits between wordle_sm (guess submit) and the VGA tile renderer (board reader).
- It is sequential by design: a fixed-latency scan FSM, not a combinational comparator.

---
 rtl/wordle_pkg.sv | 26 ++
 rtl/wordle_guess_scorer.sv | 148 ++++++++++++++
 tb/tb_wordle_guess_scorer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/wordle_pkg.sv
// Shared encodings for the Wordle board: letter/colour codes and scorer FSM states.
// The VGA tile renderer imports the same colour codes so both sides decode identically.
package wordle_pkg;

  localparam int N_LETTERS = 5;
  localparam int LETTER_W  = 8;
  localparam int ROW_W     = 3;

  localparam logic [LETTER_W-1:0] BLANK = 8'h00;

  typedef logic [1:0] colour_t;
  localparam colour_t COL_NONE = 2'b00;
  localparam colour_t COL_GRAY = 2'b01;
  localparam colour_t COL_YEL  = 2'b10;
  localparam colour_t COL_GRN  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LATCH  = 3'd1,
    S_GREEN  = 3'd2,
    S_YELLOW = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/wordle_guess_scorer.sv
// Scores one 5-letter guess against the secret with Wordle duplicate rules and
// writes the letters and colours of the scored row into the board memory.
//
// state  | meaning
// IDLE   | waiting for start
// LATCH  | capture guess/secret/row, clear colours and used flags
// GREEN  | column i exact-match check, one column per cycle
// YELLOW | guess col i vs secret col j, one pair per cycle, fixed N*N length
// WRITE  | board write of column i, one column per cycle
// DONE   | one-cycle done pulse, score/win valid
module wordle_guess_scorer
  import wordle_pkg::*;
(
  input  logic                            board_clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [N_LETTERS*LETTER_W-1:0]   guess,
  input  logic [N_LETTERS*LETTER_W-1:0]   secret,
  input  logic [ROW_W-1:0]                row,
  output logic                            busy,
  output logic                            done,
  output logic                            win,
  output logic [2*N_LETTERS-1:0]          score,
  output logic                            wr_en,
  output logic [ROW_W-1:0]                wr_row,
  output logic [2:0]                      wr_col,
  output logic [LETTER_W-1:0]             wr_letter,
  output logic [1:0]                      wr_color
);

  localparam logic [2:0] LAST = 3'(N_LETTERS - 1);

  state_t                state, state_nxt;
  logic [2:0]            idx_i, idx_j;
  logic [LETTER_W-1:0]   g_q [N_LETTERS];
  logic [LETTER_W-1:0]   s_q [N_LETTERS];
  logic [ROW_W-1:0]      row_q;
  colour_t               colour [N_LETTERS];
  logic [N_LETTERS-1:0]  used;
  logic [2*N_LETTERS-1:0] score_pack;
  logic                  all_green;

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    wr_en     = 1'b0;
    wr_row    = '0;
    wr_col    = '0;
    wr_letter = '0;
    wr_color  = COL_NONE;
    case (state)
      S_IDLE:   if (start) state_nxt = S_LATCH;
      S_LATCH:  state_nxt = S_GREEN;
      S_GREEN:  if (idx_i == LAST) state_nxt = S_YELLOW;
      S_YELLOW: if (idx_i == LAST && idx_j == LAST) state_nxt = S_WRITE;
      S_WRITE:  if (idx_i == LAST) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (state != S_IDLE) busy = 1'b1;
    if (state == S_DONE) done = 1'b1;
    if (state == S_WRITE) begin
      wr_en     = 1'b1;
      wr_row    = row_q;
      wr_col    = idx_i;
      wr_letter = g_q[idx_i];
      wr_color  = colour[idx_i];
    end
  end

  always_comb begin
    score_pack = '0;
    all_green  = 1'b1;
    for (int k = 0; k < N_LETTERS; k++) begin
      score_pack[2*(N_LETTERS-1-k) +: 2] = colour[k];
      if (colour[k] != COL_GRN) all_green = 1'b0;
    end
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      idx_i <= '0;
      idx_j <= '0;
      row_q <= '0;
      used  <= '0;
      score <= '0;
      win   <= 1'b0;
      for (int k = 0; k < N_LETTERS; k++) begin
        g_q[k]    <= '0;
        s_q[k]    <= '0;
        colour[k] <= COL_NONE;
      end
    end else begin
      case (state)
        S_LATCH: begin
          idx_i <= '0;
          idx_j <= '0;
          row_q <= row;
          used  <= '0;
          for (int k = 0; k < N_LETTERS; k++) begin
            g_q[k]    <= guess[LETTER_W*(N_LETTERS-1-k) +: LETTER_W];
            s_q[k]    <= secret[LETTER_W*(N_LETTERS-1-k) +: LETTER_W];
            colour[k] <= COL_NONE;
          end
        end
        S_GREEN: begin
          if (g_q[idx_i] == s_q[idx_i] && g_q[idx_i] != BLANK) begin
            colour[idx_i] <= COL_GRN;
            used[idx_i]   <= 1'b1;
          end
          idx_i <= (idx_i == LAST) ? 3'd0 : idx_i + 3'd1;
        end
        S_YELLOW: begin
          // An earlier yellow match for this column blocks later j, so the lowest j wins.
          if (colour[idx_i] == COL_NONE) begin
            if (g_q[idx_i] == s_q[idx_j] && !used[idx_j] && g_q[idx_i] != BLANK) begin
              colour[idx_i] <= COL_YEL;
              used[idx_j]   <= 1'b1;
            end else if (idx_j == LAST) begin
              colour[idx_i] <= COL_GRAY;
            end
          end
          if (idx_j == LAST) begin
            idx_j <= '0;
            idx_i <= (idx_i == LAST) ? 3'd0 : idx_i + 3'd1;
          end else begin
            idx_j <= idx_j + 3'd1;
          end
        end
        S_WRITE: begin
          idx_i <= (idx_i == LAST) ? 3'd0 : idx_i + 3'd1;
          if (idx_i == LAST) begin
            score <= score_pack;
            win   <= all_green;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wordle_guess_scorer.sv
// Self-checking bench for wordle_guess_scorer: table vectors, random guesses
// against a count-based Wordle model, and timing/reset corner sequences.
module tb_wordle_guess_scorer;

  logic        board_clk = 1'b0;
  logic        reset;
  logic        start;
  logic [39:0] guess, secret;
  logic [2:0]  row;
  logic        busy, done, win, wr_en;
  logic [9:0]  score;
  logic [2:0]  wr_row, wr_col;
  logic [7:0]  wr_letter;
  logic [1:0]  wr_color;

  int total = 0;
  int bad   = 0;

  wordle_guess_scorer dut (
    .board_clk (board_clk),
    .reset     (reset),
    .start     (start),
    .guess     (guess),
    .secret    (secret),
    .row       (row),
    .busy      (busy),
    .done      (done),
    .win       (win),
    .score     (score),
    .wr_en     (wr_en),
    .wr_row    (wr_row),
    .wr_col    (wr_col),
    .wr_letter (wr_letter),
    .wr_color  (wr_color)
  );

  always #5 board_clk = ~board_clk;

  typedef struct {
    logic [39:0] g;
    logic [39:0] s;
    logic [2:0]  r;
    logic [9:0]  exp_score;
    logic        exp_win;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Standard Wordle scoring: greens first, then yellows drawn from the
  // per-letter count of non-green secret letters, left to right.
  function automatic logic [9:0] model(input logic [39:0] g, input logic [39:0] s);
    logic [7:0] gl [5];
    logic [7:0] sl [5];
    logic [1:0] c  [5];
    int         cnt [256];
    logic [9:0] res;
    for (int k = 0; k < 256; k++) cnt[k] = 0;
    for (int k = 0; k < 5; k++) begin
      gl[k] = g[(4-k)*8 +: 8];
      sl[k] = s[(4-k)*8 +: 8];
    end
    for (int k = 0; k < 5; k++) begin
      if (gl[k] == sl[k] && gl[k] != 8'h00) c[k] = 2'b11;
      else begin
        c[k] = 2'b01;
        if (sl[k] != 8'h00) cnt[sl[k]]++;
      end
    end
    for (int k = 0; k < 5; k++)
      if (c[k] != 2'b11 && gl[k] != 8'h00 && cnt[gl[k]] > 0) begin
        c[k] = 2'b10;
        cnt[gl[k]]--;
      end
    res = '0;
    for (int k = 0; k < 5; k++) res[(4-k)*2 +: 2] = c[k];
    return res;
  endfunction

  // Called at a negedge with the DUT idle. mode 0: plain; 1: second start with
  // another guess at cycle 10; 2: start held high through DONE (back-to-back).
  task automatic run_op(input logic [39:0] g, input logic [39:0] s, input logic [2:0] r,
                        input logic [9:0] esc, input logic ew, input int mode, input string tag);
    int busy_cnt = 0, done_cnt = 0, done_cyc = 0, wr_cnt = 0, c;
    bit seen;
    guess = g; secret = s; row = r; start = 1'b1;
    @(negedge board_clk);
    for (int k = 1; k <= 38; k++) begin
      if (k > 1) @(negedge board_clk);
      if (mode != 2 && k == 1) start = 1'b0;
      if (mode == 1 && k == 10) begin start = 1'b1; guess = "ZZZZZ"; end
      if (mode == 1 && k == 11) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_cyc = k; end
      if (wr_en) begin
        wr_cnt++;
        chk({tag, " wr_cycle_in_32_36"}, 64'(k >= 32 && k <= 36), 64'd1);
        if (k >= 32 && k <= 36) begin
          c = k - 32;
          chk({tag, " wr_col"},    64'(wr_col), 64'(c));
          chk({tag, " wr_row"},    64'(wr_row), 64'(r));
          chk({tag, " wr_letter"}, 64'(wr_letter), 64'(g[(4-c)*8 +: 8]));
          chk({tag, " wr_color"},  64'(wr_color), 64'(esc[(4-c)*2 +: 2]));
        end
      end
      if (k == 37) begin
        chk({tag, " score"}, 64'(score), 64'(esc));
        chk({tag, " win"},   64'(win),   64'(ew));
      end
      if (k == 38) begin
        chk({tag, " score_hold"}, 64'(score), 64'(esc));
        chk({tag, " win_hold"},   64'(win),   64'(ew));
        chk({tag, " busy_low_after_done"}, 64'(busy), 64'd0);
      end
    end
    chk({tag, " busy_cycles"}, 64'(busy_cnt), 64'd37);
    chk({tag, " done_count"},  64'(done_cnt), 64'd1);
    chk({tag, " done_cycle"},  64'(done_cyc), 64'd37);
    chk({tag, " wr_count"},    64'(wr_cnt),   64'd5);
    if (mode == 2) begin
      @(negedge board_clk);
      chk({tag, " b2b_busy_next"}, 64'(busy), 64'd1);
      start = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 60 && !seen; k++) begin
        @(negedge board_clk);
        if (done) seen = 1'b1;
      end
      chk({tag, " b2b_done_seen"}, 64'(seen), 64'd1);
      chk({tag, " b2b_score"}, 64'(score), 64'(esc));
      @(negedge board_clk);
    end
  endtask

  vec_t vecs [6];
  logic [39:0] rg, rs;
  logic [9:0]  resc;
  int          wr_after, busy_after;

  initial begin
    vecs[0] = '{g: "CRANE", s: "CRANE", r: 3'd2, exp_score: 10'h3FF, exp_win: 1'b1};
    vecs[1] = '{g: "BABES", s: "ABBEY", r: 3'd0, exp_score: 10'h2BD, exp_win: 1'b0};
    vecs[2] = '{g: "OOOOO", s: "ROBOT", r: 3'd5, exp_score: 10'h1DD, exp_win: 1'b0};
    vecs[3] = '{g: {"AB", 8'h00, "DE"}, s: {"AB", 8'h00, "DE"}, r: 3'd1, exp_score: 10'h3DF, exp_win: 1'b0};
    vecs[4] = '{g: "XYZWV", s: "ABCDE", r: 3'd3, exp_score: 10'h155, exp_win: 1'b0};
    vecs[5] = '{g: "EABCD", s: "ABCDE", r: 3'd4, exp_score: 10'h2AA, exp_win: 1'b0};

    reset = 1'b1; start = 1'b0; guess = '0; secret = '0; row = '0;
    #1;
    chk("reset_outputs", 64'({busy, done, win, score, wr_en, wr_row, wr_col, wr_letter, wr_color}), 64'd0);
    repeat (3) @(negedge board_clk);
    reset = 1'b0;
    @(negedge board_clk);

    for (int v = 0; v < 6; v++)
      run_op(vecs[v].g, vecs[v].s, vecs[v].r, vecs[v].exp_score, vecs[v].exp_win, 0,
             $sformatf("vec%0d", v));

    run_op(vecs[1].g, vecs[1].s, 3'd3, vecs[1].exp_score, 1'b0, 1, "busy_start");
    run_op(vecs[2].g, vecs[2].s, 3'd4, vecs[2].exp_score, 1'b0, 2, "held_start");

    // Reset in the middle of the YELLOW scan.
    guess = "CRANE"; secret = "CRANE"; row = 3'd2; start = 1'b1;
    @(negedge board_clk);
    start = 1'b0;
    repeat (14) @(negedge board_clk);
    reset = 1'b1;
    #1;
    chk("midscan_reset_outputs",
        64'({busy, done, win, score, wr_en, wr_row, wr_col, wr_letter, wr_color}), 64'd0);
    @(negedge board_clk);
    reset = 1'b0;
    wr_after = 0; busy_after = 0;
    repeat (45) begin
      @(negedge board_clk);
      if (wr_en) wr_after++;
      if (busy) busy_after++;
    end
    chk("post_reset_no_wr", 64'(wr_after), 64'd0);
    chk("post_reset_idle",  64'(busy_after), 64'd0);
    run_op(vecs[0].g, vecs[0].s, 3'd2, 10'h3FF, 1'b1, 0, "after_reset");

    for (int n = 0; n < 24; n++) begin
      for (int k = 0; k < 5; k++) begin
        int a, b;
        a = $urandom_range(0, 4);
        b = $urandom_range(0, 4);
        rg[(4-k)*8 +: 8] = (a == 0) ? 8'h00 : 8'(8'h40 + a);
        rs[(4-k)*8 +: 8] = (b == 0) ? 8'h00 : 8'(8'h40 + b);
      end
      if (n % 6 == 0) rs = rg;
      resc = model(rg, rs);
      run_op(rg, rs, 3'($urandom_range(0, 5)), resc, resc == 10'h3FF, 0,
             $sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
